// File: rtl/mda_adc_pkg.sv
// Shared constants, config-word bit positions and FSM state type for the
// mda_adc responder.
package mda_adc_pkg;

    localparam int DATA_BITS_DEF = 12;
    localparam int CMD_BITS_DEF  = 6;
    localparam int CH_NUM_DEF    = 8;

    localparam int CFG_SD  = 5;
    localparam int CFG_OS  = 4;
    localparam int CFG_S1  = 3;
    localparam int CFG_S0  = 2;
    localparam int CFG_UNI = 1;
    localparam int CFG_SLP = 0;

    // ch0, unipolar, no sleep
    localparam logic [5:0] CFG_RESET = 6'b100010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/mda_adc_sync_edge.sv
// Two-flop synchronizer with registered rise/fall pulses; the pulses line up
// with the cycle in which the synced level changes.
module mda_adc_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        rise_d = meta_q & ~sync_q;
        fall_d = ~meta_q & sync_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level = sync_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/mda_adc_responder.sv
// LTC2308-style SPI ADC responder (chip side of CONVST/SCK/SDI/SDO).
// Define MDA_ADC_RESP_TIMING_CHECK_EN to enable the sticky proto_err checker.
module mda_adc_responder
    import mda_adc_pkg::*;
#(
    parameter int CONV_CYCLES       = 64,
    parameter int DATA_BITS         = DATA_BITS_DEF,
    parameter int CMD_BITS          = CMD_BITS_DEF,
    parameter int CH_NUM            = CH_NUM_DEF,
    parameter int MIN_CONVST_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ADC_CONVST,
    input  logic                        ADC_SCK,
    input  logic                        ADC_SDI,
    output logic                        ADC_SDO,
    input  logic [CH_NUM*DATA_BITS-1:0] sample_data,
    output logic [CMD_BITS-1:0]         cur_cfg,
    output logic                        cfg_update,
    output logic [15:0]                 conv_count,
    output logic                        busy,
    output logic                        proto_err
);

    localparam int TW = $clog2(CONV_CYCLES + 1);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int CW = $clog2(CMD_BITS + 1);

    logic convst_level, convst_rise, convst_fall;
    logic sck_level, sck_rise, sck_fall;
    logic sdi_level, sdi_rise, sdi_fall;

    mda_adc_sync_edge u_sync_convst (.clk(clk), .reset(reset), .din(ADC_CONVST),
        .level(convst_level), .rise(convst_rise), .fall(convst_fall));
    mda_adc_sync_edge u_sync_sck (.clk(clk), .reset(reset), .din(ADC_SCK),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall));
    mda_adc_sync_edge u_sync_sdi (.clk(clk), .reset(reset), .din(ADC_SDI),
        .level(sdi_level), .rise(sdi_rise), .fall(sdi_fall));

    state_t                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic [BW-1:0]         bitcnt_q, bitcnt_d;
    logic [CMD_BITS-1:0]   cmd_q, cmd_d;
    logic [CW-1:0]         cmdcnt_q, cmdcnt_d;
    logic [CMD_BITS-1:0]   cur_cfg_q, cur_cfg_d;
    logic                  cfg_update_q, cfg_update_d;
    logic [15:0]           conv_count_q, conv_count_d;
    logic                  sdo_q, sdo_d;

    logic [DATA_BITS-1:0]  chan_sample [CH_NUM];
    logic [2:0]            ch_sel;
    logic [DATA_BITS-1:0]  conv_word;
    logic                  conv_start, conv_done, shift_done;

    genvar gi;
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
            assign chan_sample[gi] = sample_data[DATA_BITS*gi +: DATA_BITS];
        end
    endgenerate

    // Channel number is scattered across the config word: {S1, S0, OS}.
    assign ch_sel = {cur_cfg_q[CFG_S1], cur_cfg_q[CFG_S0], cur_cfg_q[CFG_OS]};

    always_comb begin
        conv_word = chan_sample[ch_sel];
        if (!cur_cfg_q[CFG_UNI]) begin
            conv_word[DATA_BITS-1] = ~conv_word[DATA_BITS-1];
        end
    end

    assign conv_start = convst_rise && (state_q != CONV);
    assign conv_done  = (state_q == CONV) && (timer_q == TW'(CONV_CYCLES - 1));
    assign shift_done = (state_q == SHIFT) && sck_fall && (bitcnt_q == BW'(DATA_BITS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            cmd_q        <= '0;
            cmdcnt_q     <= '0;
            cur_cfg_q    <= CMD_BITS'(CFG_RESET);
            cfg_update_q <= 1'b0;
            conv_count_q <= '0;
            sdo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            cmd_q        <= cmd_d;
            cmdcnt_q     <= cmdcnt_d;
            cur_cfg_q    <= cur_cfg_d;
            cfg_update_q <= cfg_update_d;
            conv_count_q <= conv_count_d;
            sdo_q        <= sdo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (convst_rise) state_d = CONV;
            CONV:    if (conv_done) state_d = SHIFT;
            SHIFT: begin
                if (convst_rise)     state_d = CONV;
                else if (shift_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        timer_d      = timer_q;
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        cmd_d        = cmd_q;
        cmdcnt_d     = cmdcnt_q;
        cur_cfg_d    = cur_cfg_q;
        cfg_update_d = 1'b0;
        conv_count_d = conv_count_q;
        sdo_d        = sdo_q;
        case (state_q)
            CONV: begin
                timer_d = timer_q + 1'b1;
                if (conv_done) begin
                    sdo_d    = shreg_q[DATA_BITS-1];
                    bitcnt_d = '0;
                    cmd_d    = '0;
                    cmdcnt_d = '0;
                end
            end
            SHIFT: begin
                if (sck_rise && (cmdcnt_q < CW'(CMD_BITS))) begin
                    cmd_d    = {cmd_q[CMD_BITS-2:0], sdi_level};
                    cmdcnt_d = cmdcnt_q + 1'b1;
                    if (cmdcnt_q == CW'(CMD_BITS - 1)) begin
                        cur_cfg_d    = {cmd_q[CMD_BITS-2:0], sdi_level};
                        cfg_update_d = 1'b1;
                    end
                end
                if (sck_fall) begin
                    bitcnt_d = bitcnt_q + 1'b1;
                    shreg_d  = shreg_q << 1;
                    sdo_d    = (bitcnt_q < BW'(DATA_BITS - 1)) ? shreg_q[DATA_BITS-2] : 1'b0;
                end
            end
            default: ;
        endcase
        // A new conversion (also an abort from SHIFT) overrides the shift path.
        if (conv_start) begin
            shreg_d      = conv_word;
            conv_count_d = conv_count_q + 16'd1;
            timer_d      = '0;
            sdo_d        = 1'b0;
        end
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    assign ADC_SDO    = sdo_q;
    assign cur_cfg    = cur_cfg_q;
    assign cfg_update = cfg_update_q;
    assign conv_count = conv_count_q;

    logic unused_inputs;
    assign unused_inputs = sck_level ^ sdi_rise ^ sdi_fall;

`ifdef MDA_ADC_RESP_TIMING_CHECK_EN
    localparam int HW = $clog2(MIN_CONVST_CYCLES + 1) + 1;

    logic [HW-1:0] hi_cnt_q, hi_cnt_d;
    logic          proto_err_q, proto_err_d;

    always_comb begin
        hi_cnt_d = hi_cnt_q;
        if (convst_rise) begin
            hi_cnt_d = HW'(1);
        end else if (convst_level && (hi_cnt_q != '1)) begin
            hi_cnt_d = hi_cnt_q + 1'b1;
        end
        proto_err_d = proto_err_q;
        if ((state_q == CONV) && (sck_rise || sck_fall)) proto_err_d = 1'b1;
        if ((state_q == SHIFT) && convst_rise)           proto_err_d = 1'b1;
        if (convst_fall && (hi_cnt_q < HW'(MIN_CONVST_CYCLES))) proto_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_cnt_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            hi_cnt_q    <= hi_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;
`else
    logic unused_timing;
    assign unused_timing = convst_level ^ convst_fall ^ (MIN_CONVST_CYCLES > 0);
    assign proto_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mda_adc_responder.sv
// Directed bench for mda_adc_responder: scoreboard of expected readback words,
// immediate assertions at every comparison point.
module tb_mda_adc_responder;

    localparam int CONV_CYCLES = 64;
    localparam int DB          = 12;
    localparam int CB          = 6;
    localparam int CHN         = 8;

`ifdef MDA_ADC_RESP_TIMING_CHECK_EN
    localparam logic PE_EXP = 1'b1;
`else
    localparam logic PE_EXP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              ADC_CONVST, ADC_SCK, ADC_SDI;
    logic              ADC_SDO;
    logic [CHN*DB-1:0] sample_data;
    logic [CB-1:0]     cur_cfg;
    logic              cfg_update;
    logic [15:0]       conv_count;
    logic              busy;
    logic              proto_err;

    mda_adc_responder #(
        .CONV_CYCLES(CONV_CYCLES), .DATA_BITS(DB), .CMD_BITS(CB), .CH_NUM(CHN),
        .MIN_CONVST_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset), .ADC_CONVST(ADC_CONVST), .ADC_SCK(ADC_SCK),
        .ADC_SDI(ADC_SDI), .ADC_SDO(ADC_SDO), .sample_data(sample_data),
        .cur_cfg(cur_cfg), .cfg_update(cfg_update), .conv_count(conv_count),
        .busy(busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          upd_total = 0;
    logic [11:0] exp_q[$];
    logic [5:0]  exp_cfg;
    logic [15:0] exp_count;
    logic [11:0] cap;
    int          upd_before;

    always @(negedge clk) if (cfg_update === 1'b1) upd_total <= upd_total + 1;

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: channel = 4*S1 + 2*S0 + OS; bipolar flips the sign bit.
    function automatic logic [11:0] model(input logic [5:0] cfg, input logic [CHN*DB-1:0] sd);
        int          ch;
        logic [11:0] w;
        ch = (cfg[3] ? 4 : 0) + (cfg[2] ? 2 : 0) + (cfg[4] ? 1 : 0);
        w  = sd[ch*DB +: DB];
        if (cfg[1] == 1'b0) w = w ^ 12'h800;
        return w;
    endfunction

    task automatic set_ch(input int ch, input logic [11:0] v);
        sample_data[ch*DB +: DB] = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clks(3);
        reset = 1'b0;
        exp_cfg   = 6'b100010;
        exp_count = 16'd0;
        exp_q.delete();
    endtask

    task automatic convst();
        exp_q.push_back(model(exp_cfg, sample_data));
        exp_count++;
        ADC_CONVST = 1'b1;
        clks(4);
        ADC_CONVST = 1'b0;
    endtask

    task automatic xfer(input int n, input logic [5:0] sdi, output logic [11:0] c);
        c = '0;
        for (int i = 0; i < n; i++) begin
            ADC_SDI = (i < 6) ? sdi[5-i] : 1'b0;
            clks(3);
            @(negedge clk) c = {c[10:0], ADC_SDO};
            @(posedge clk) #1 ADC_SCK = 1'b1;
            clks(4);
            ADC_SCK = 1'b0;
        end
        ADC_SDI = 1'b0;
        if (n >= 6) exp_cfg = sdi;
        clks(6);
    endtask

    task automatic readback(input string tag, input int n, input logic [5:0] sdi);
        logic [11:0] e;
        logic [11:0] c;
        xfer(n, sdi, c);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, c, e >> (12 - n));
        end
    endtask

    initial begin
        reset = 1'b1; ADC_CONVST = 1'b0; ADC_SCK = 1'b0; ADC_SDI = 1'b0;
        sample_data = '0;
        do_reset();

        @(negedge clk);
        chk("rst_sdo", ADC_SDO, 0);
        chk("rst_cfg", cur_cfg, 6'h22);
        chk("rst_upd", cfg_update, 0);
        chk("rst_count", conv_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_perr", proto_err, 0);

        // 1: CONVST only, data MSB appears CONV_CYCLES+3 clk after the pin edge
        set_ch(0, 12'hABC);
        @(posedge clk) #1 ADC_CONVST = 1'b1;
        repeat (4) @(posedge clk);
        #1 ADC_CONVST = 1'b0;
        repeat (CONV_CYCLES - 2) @(posedge clk);
        @(negedge clk);
        chk("t1_sdo_early", ADC_SDO, 0);
        chk("t1_busy_conv", busy, 1);
        @(posedge clk);
        @(negedge clk);
        chk("t1_sdo_msb", ADC_SDO, 1);
        chk("t1_busy", busy, 1);
        chk("t1_count", conv_count, 1);

        // 2: full transfer, new config ch1 unipolar
        do_reset();
        convst();
        clks(CONV_CYCLES);
        upd_before = upd_total;
        readback("t2_data", 12, 6'b110010);
        chk("t2_cfg", cur_cfg, exp_cfg);
        chk("t2_upd_once", upd_total - upd_before, 1);
        chk("t2_busy_idle", busy, 0);
        chk("t2_perr", proto_err, 0);
        chk("t2_count", conv_count, exp_count);

        // 3: ch1 unipolar, then bipolar
        set_ch(1, 12'h123);
        convst();
        clks(CONV_CYCLES);
        readback("t3_uni", 12, 6'b110000);
        chk("t3_cfg", cur_cfg, 6'h30);
        convst();
        clks(CONV_CYCLES);
        readback("t3_bip", 12, 6'b110000);

        // 4: short transfer, then abort by new CONVST
        convst();
        clks(CONV_CYCLES);
        readback("t4_short", 4, 6'b110010);
        convst();
        chk("t4_cfg", cur_cfg, 6'h30);
        chk("t4_count", conv_count, exp_count);
        chk("t4_perr", proto_err, PE_EXP);
        chk("t4_busy", busy, 1);
        clks(CONV_CYCLES);
        readback("t4_data", 12, 6'b110000);

        // 5: SCK activity during CONV
        do_reset();
        set_ch(0, 12'h5A5);
        convst();
        for (int k = 0; k < 2; k++) begin
            ADC_SCK = 1'b1;
            clks(4);
            ADC_SCK = 1'b0;
            clks(4);
        end
        clks(CONV_CYCLES);
        chk("t5_perr", proto_err, PE_EXP);
        readback("t5_data", 12, 6'b100010);

        // 6: reset in the middle of SHIFT
        do_reset();
        set_ch(0, 12'hFFF);
        set_ch(1, 12'hFFF);
        convst();
        clks(CONV_CYCLES);
        readback("t6_first", 12, 6'b110010);
        convst();
        clks(CONV_CYCLES);
        readback("t6_part", 5, 6'b110000);
        chk("t6_sdo_mid", ADC_SDO, 1);
        chk("t6_busy_mid", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_sdo", ADC_SDO, 0);
        chk("t6_busy", busy, 0);
        chk("t6_cfg", cur_cfg, 6'h22);
        chk("t6_count", conv_count, 0);
        #1 reset = 1'b0;
        clks(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
